wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback arbiter that merges the buffered result streams of several execute-unit output queues into the single writeback port. It selects one valid input per cycle under round-robin priority. The selected message is captured in a one-entry pipeline register that drives the writeback stage. It sits directly downstream of the per-unit execute output queues and directly upstream of writeback/commit.

Parameters:
p_num_in, 4, number of execute-queue input channels (2..8)
p_seq_num_bits, 5, width of the instruction sequence number
p_phys_addr_bits, 6, width of physical register indices

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; asynchronous, active-low (asserted at 0)
in_val  input  p_num_in  per-channel valid
in_rdy  output  p_num_in  per-channel ready (at most one bit high per cycle)
in_pc  input  p_num_in*32  per-channel PC; channel i at bits [32i+31:32i]
in_waddr  input  p_num_in*5  per-channel architectural destination register
in_wdata  input  p_num_in*32  per-channel result data
in_wen  input  p_num_in  per-channel write enable
in_seq_num  input  p_num_in*p_seq_num_bits  per-channel sequence number
in_preg  input  p_num_in*p_phys_addr_bits  per-channel destination physical register
in_ppreg  input  p_num_in*p_phys_addr_bits  per-channel previous physical register
out_val  output  1  writeback message valid
out_rdy  input  1  writeback stage ready
out_pc, out_waddr, out_wdata, out_wen, out_seq_num, out_preg, out_ppreg  output  32/5/32/1/p_seq_num_bits/p_phys_addr_bits/p_phys_addr_bits  registered message fields

Behaviour:
- Handshake: a transfer occurs on a channel when val & rdy are both high in the same cycle. in_rdy never depends combinationally on in_val of the same channel, except through the arbitration grant.
- Reset (rst=0, asynchronous): out_val=0; all out_* payload registers=0; priority pointer ptr=0. in_rdy is 0 while rst=0.
- Pipeline register: the block holds a single entry, reg_full (reg_full == out_val).
  - can_accept = !reg_full | out_rdy. Pipelined throughput is one message per cycle, with no bubble when out_rdy stays high.
- Arbitration: combinational round-robin over in_val, starting at index ptr and scanning ptr, ptr+1, ... mod p_num_in.
  - grant = the first valid index found; grant is one-hot or zero.
  - in_rdy[i] = grant[i] & can_accept.
  - Channels that are not granted see in_rdy=0.
- Capture: on the clock edge where any in_val[i] & in_rdy[i] holds, the out_* fields load channel i's fields and out_val becomes 1. Latency is exactly 1 cycle from input handshake to out_val.
- Drain without refill: if out_val & out_rdy and no input is granted, out_val becomes 0. Payload registers may hold their stale value.
- Stall: if out_val & !out_rdy, all out_* fields hold stable, and in_rdy is all-zero.
- Pointer update: ptr changes only on a successful input handshake, to (granted index + 1) mod p_num_in, wrapping from p_num_in-1 to 0. With no handshake, ptr holds, including while stalled with requests pending.
- Fairness: a continuously valid channel is granted within p_num_in accepted transfers.
- No message is dropped or duplicated. Messages from the same channel leave in arrival order.
- Reset asserted mid-operation: out_val drops immediately (asynchronously) and the in-flight entry is discarded. After deassertion, arbitration restarts at ptr=0.
- The wen=0 messages pass through unchanged; the arbiter does not filter on wen.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then rst=1 with all in_val=0 -> out_val=0, in_rdy=4'b0000, out_* all zero.
2. Single channel: in_val=4'b0100 carrying pc=0x200, waddr=7, wdata=0xDEADBEEF, wen=1, seq_num=3, preg=12, ppreg=5, with out_rdy=1 -> in_rdy=4'b0100 that cycle. Next cycle out_val=1 with identical fields; ptr=3.
3. Round-robin fairness: all four in_val held high, out_rdy=1 for 8 cycles starting at ptr=0 -> grants in order 0,1,2,3,0,1,2,3. Exactly one in_rdy bit high each cycle; out_val stays high with no bubbles.
4. Back-pressure: out_val=1 holding seq_num=9 with out_rdy=0 for 3 cycles while in_val=4'b0011 -> in_rdy=0 and out_* stable for all 3 cycles. When out_rdy=1, the pending grant (ptr's channel) is accepted in that same cycle, and the next out message follows one cycle later.
5. Pointer wrap and skip: ptr=3, in_val=4'b0101 -> channel 0 granted first, ptr becomes 1. The next grant goes to channel 2 and ptr becomes 3.
6. Reset mid-stream: out_val=1 with an entry pending, then rst pulsed low between clock edges -> out_val=0 without waiting for a clock edge. After release, channel 0 is granted first when in_val=4'b1111.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of several execute-queue result streams
// into a single one-entry pipeline register feeding the writeback stage.
module wb_arbiter #(
  parameter int p_num_in         = 4,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [p_num_in-1:0]                    in_val,
  output logic [p_num_in-1:0]                    in_rdy,
  input  logic [p_num_in*32-1:0]                 in_pc,
  input  logic [p_num_in*5-1:0]                  in_waddr,
  input  logic [p_num_in*32-1:0]                 in_wdata,
  input  logic [p_num_in-1:0]                    in_wen,
  input  logic [p_num_in*p_seq_num_bits-1:0]     in_seq_num,
  input  logic [p_num_in*p_phys_addr_bits-1:0]   in_preg,
  input  logic [p_num_in*p_phys_addr_bits-1:0]   in_ppreg,
  output logic                                   out_val,
  input  logic                                   out_rdy,
  output logic [31:0]                            out_pc,
  output logic [4:0]                             out_waddr,
  output logic [31:0]                            out_wdata,
  output logic                                   out_wen,
  output logic [p_seq_num_bits-1:0]              out_seq_num,
  output logic [p_phys_addr_bits-1:0]            out_preg,
  output logic [p_phys_addr_bits-1:0]            out_ppreg
);

  localparam int PTR_W = $clog2(p_num_in);

  logic [PTR_W-1:0]            ptr_q, ptr_d, grant_idx;
  logic [PTR_W:0]              scan_sum, ptr_inc;
  logic [p_num_in-1:0]         grant;
  logic                        any_grant, can_accept, fire;
  logic                        out_val_q, out_val_d;
  logic [31:0]                 out_pc_q, out_pc_d;
  logic [4:0]                  out_waddr_q, out_waddr_d;
  logic [31:0]                 out_wdata_q, out_wdata_d;
  logic                        out_wen_q, out_wen_d;
  logic [p_seq_num_bits-1:0]   out_seq_num_q, out_seq_num_d;
  logic [p_phys_addr_bits-1:0] out_preg_q, out_preg_d;
  logic [p_phys_addr_bits-1:0] out_ppreg_q, out_ppreg_d;

  // Scan ptr, ptr+1, ... (mod p_num_in); the first valid channel wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    scan_sum  = '0;
    for (int k = 0; k < p_num_in; k++) begin
      scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(p_num_in))
        scan_sum = scan_sum - (PTR_W+1)'(p_num_in);
      if (!any_grant && in_val[scan_sum[PTR_W-1:0]]) begin
        any_grant                   = 1'b1;
        grant_idx                   = scan_sum[PTR_W-1:0];
        grant[scan_sum[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

  assign can_accept = !out_val_q || out_rdy;
  assign fire       = any_grant && can_accept;
  // Gate with rst so no channel sees ready while reset is held.
  assign in_rdy     = grant & {p_num_in{can_accept & rst}};

  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (ptr_inc == (PTR_W+1)'(p_num_in))
      ptr_inc = '0;
    ptr_d     = fire ? ptr_inc[PTR_W-1:0] : ptr_q;
    out_val_d = fire || (out_val_q && !out_rdy);
  end

  assign out_pc_d      = in_pc[grant_idx*32 +: 32];
  assign out_waddr_d   = in_waddr[grant_idx*5 +: 5];
  assign out_wdata_d   = in_wdata[grant_idx*32 +: 32];
  assign out_wen_d     = in_wen[grant_idx];
  assign out_seq_num_d = in_seq_num[grant_idx*p_seq_num_bits +: p_seq_num_bits];
  assign out_preg_d    = in_preg[grant_idx*p_phys_addr_bits +: p_phys_addr_bits];
  assign out_ppreg_d   = in_ppreg[grant_idx*p_phys_addr_bits +: p_phys_addr_bits];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      out_val_q     <= 1'b0;
      out_pc_q      <= '0;
      out_waddr_q   <= '0;
      out_wdata_q   <= '0;
      out_wen_q     <= 1'b0;
      out_seq_num_q <= '0;
      out_preg_q    <= '0;
      out_ppreg_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      out_val_q <= out_val_d;
      if (fire) begin
        out_pc_q      <= out_pc_d;
        out_waddr_q   <= out_waddr_d;
        out_wdata_q   <= out_wdata_d;
        out_wen_q     <= out_wen_d;
        out_seq_num_q <= out_seq_num_d;
        out_preg_q    <= out_preg_d;
        out_ppreg_q   <= out_ppreg_d;
      end
    end
  end

  assign out_val     = out_val_q;
  assign out_pc      = out_pc_q;
  assign out_waddr   = out_waddr_q;
  assign out_wdata   = out_wdata_q;
  assign out_wen     = out_wen_q;
  assign out_seq_num = out_seq_num_q;
  assign out_preg    = out_preg_q;
  assign out_ppreg   = out_ppreg_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner cases and
// randomized traffic checked against a round-robin reference model.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int SB = 5;
  localparam int PB = 6;
  localparam int MW = 32 + 5 + 32 + 1 + SB + PB + PB;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       in_val = '0;
  logic [N-1:0]       in_rdy;
  logic [N*32-1:0]    in_pc;
  logic [N*5-1:0]     in_waddr;
  logic [N*32-1:0]    in_wdata;
  logic [N-1:0]       in_wen;
  logic [N*SB-1:0]    in_seq_num;
  logic [N*PB-1:0]    in_preg;
  logic [N*PB-1:0]    in_ppreg;
  logic               out_val;
  logic               out_rdy = 1'b0;
  logic [31:0]        out_pc;
  logic [4:0]         out_waddr;
  logic [31:0]        out_wdata;
  logic               out_wen;
  logic [SB-1:0]      out_seq_num;
  logic [PB-1:0]      out_preg;
  logic [PB-1:0]      out_ppreg;

  logic [31:0] t_pc    [N];
  logic [4:0]  t_waddr [N];
  logic [31:0] t_wdata [N];
  logic        t_wen   [N];
  logic [SB-1:0] t_seq [N];
  logic [PB-1:0] t_preg  [N];
  logic [PB-1:0] t_ppreg [N];

  always_comb begin
    in_pc = '0; in_waddr = '0; in_wdata = '0; in_wen = '0;
    in_seq_num = '0; in_preg = '0; in_ppreg = '0;
    for (int i = 0; i < N; i++) begin
      in_pc[32*i +: 32]     = t_pc[i];
      in_waddr[5*i +: 5]    = t_waddr[i];
      in_wdata[32*i +: 32]  = t_wdata[i];
      in_wen[i]             = t_wen[i];
      in_seq_num[SB*i +: SB] = t_seq[i];
      in_preg[PB*i +: PB]   = t_preg[i];
      in_ppreg[PB*i +: PB]  = t_ppreg[i];
    end
  end

  wire [MW-1:0] out_msg = {out_pc, out_waddr, out_wdata, out_wen, out_seq_num, out_preg, out_ppreg};

  wb_arbiter #(.p_num_in(N), .p_seq_num_bits(SB), .p_phys_addr_bits(PB)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wen(in_wen),
    .in_seq_num(in_seq_num), .in_preg(in_preg), .in_ppreg(in_ppreg),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_pc(out_pc), .out_waddr(out_waddr), .out_wdata(out_wdata), .out_wen(out_wen),
    .out_seq_num(out_seq_num), .out_preg(out_preg), .out_ppreg(out_ppreg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a single held message, a priority pointer.
  logic          m_val;
  int            m_ptr;
  logic [MW-1:0] m_msg;
  logic [N-1:0]  seen_rdy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [MW-1:0] chan_msg(input int i);
    return {t_pc[i], t_waddr[i], t_wdata[i], t_wen[i], t_seq[i], t_preg[i], t_ppreg[i]};
  endfunction

  task automatic model_reset();
    m_val = 1'b0;
    m_ptr = 0;
    m_msg = '0;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      t_pc[i]    = $urandom;
      t_waddr[i] = 5'($urandom);
      t_wdata[i] = $urandom;
      t_wen[i]   = 1'($urandom);
      t_seq[i]   = SB'($urandom);
      t_preg[i]  = PB'($urandom);
      t_ppreg[i] = PB'($urandom);
    end
  endtask

  // One cycle: called just after a falling edge with inputs already set.
  task automatic step();
    int g;
    logic can;
    logic [N-1:0] exp_rdy;
    #1;
    can     = !m_val || out_rdy;
    g       = rr_pick(in_val, m_ptr);
    exp_rdy = (g >= 0 && can) ? N'(1 << g) : '0;
    seen_rdy = in_rdy;
    check("in_rdy", 128'(in_rdy), 128'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != '0) begin
      m_msg = chan_msg(g);
      m_val = 1'b1;
      m_ptr = (g + 1) % N;
    end else if (m_val && out_rdy) begin
      m_val = 1'b0;
    end
    #1;
    check("out_val", 128'(out_val), 128'(m_val));
    if (m_val) check("out_msg", 128'(out_msg), 128'(m_msg));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_val = '1;
    out_rdy = 1'b1;
    #1;
    check("rst_in_rdy", 128'(in_rdy), 128'(0));
    check("rst_out_val", 128'(out_val), 128'(0));
    repeat (2) @(negedge clk);
    model_reset();
    in_val = '0;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_val;
    logic [SB-1:0] exp_seq;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 5'd1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 5'd2};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 5'd3};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 5'd4};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 5'd1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 5'd0};
    tbl[6]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 5'd3};
    tbl[7]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 5'd3};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 5'd1};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 5'd3};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 5'd0};
    tbl[11] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 5'd4};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 5'd4};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 5'd0};

    for (int i = 0; i < N; i++) begin
      t_pc[i] = '0; t_waddr[i] = '0; t_wdata[i] = '0; t_wen[i] = 1'b0;
      t_seq[i] = '0; t_preg[i] = '0; t_ppreg[i] = '0;
    end
    model_reset();

    // Reset then idle
    do_reset();
    #1;
    check("idle_in_rdy", 128'(in_rdy), 128'(0));
    check("idle_out_val", 128'(out_val), 128'(0));
    check("idle_out_msg", 128'(out_msg), 128'(0));
    step();

    // Vector table: channel i carries seq_num i+1
    do_reset();
    randomize_payload();
    for (int i = 0; i < N; i++) t_seq[i] = SB'(i + 1);
    foreach (tbl[r]) begin
      in_val  = tbl[r].v;
      out_rdy = tbl[r].ordy;
      step();
      check($sformatf("tbl%0d_rdy", r), 128'(seen_rdy), 128'(tbl[r].exp_rdy));
      check($sformatf("tbl%0d_val", r), 128'(out_val), 128'(tbl[r].exp_val));
      if (tbl[r].exp_val) check($sformatf("tbl%0d_seq", r), 128'(out_seq_num), 128'(tbl[r].exp_seq));
    end

    // Single channel with fixed payload, from ptr=0
    do_reset();
    t_pc[2] = 32'h200; t_waddr[2] = 5'd7; t_wdata[2] = 32'hDEADBEEF; t_wen[2] = 1'b1;
    t_seq[2] = 5'd3; t_preg[2] = 6'd12; t_ppreg[2] = 6'd5;
    in_val = 4'b0100; out_rdy = 1'b1;
    step();
    check("single_rdy", 128'(seen_rdy), 128'(4'b0100));
    check("single_pc", 128'(out_pc), 128'(32'h200));
    check("single_wdata", 128'(out_wdata), 128'(32'hDEADBEEF));
    check("single_fields", 128'({out_waddr, out_wen, out_seq_num, out_preg, out_ppreg}),
          128'({5'd7, 1'b1, 5'd3, 6'd12, 6'd5}));

    // Wrap and skip: ptr=3, channels 0 and 2 requesting
    in_val = 4'b0101;
    step();
    check("wrap_grant0", 128'(seen_rdy), 128'(4'b0001));
    step();
    check("skip_grant2", 128'(seen_rdy), 128'(4'b0100));

    // Back-pressure: ptr=3, load seq 9 from channel 0 then stall 3 cycles
    t_seq[0] = 5'd9; t_seq[1] = 5'd17;
    in_val = 4'b0011;
    step();
    check("bp_load_seq", 128'(out_seq_num), 128'(5'd9));
    t_seq[0] = 5'd20;
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_stall_rdy", 128'(seen_rdy), 128'(0));
      check("bp_stall_seq", 128'(out_seq_num), 128'(5'd9));
    end
    out_rdy = 1'b1;
    step();
    check("bp_release_rdy", 128'(seen_rdy), 128'(4'b0010));
    check("bp_next_seq", 128'(out_seq_num), 128'(5'd17));

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      randomize_payload();
      in_val  = N'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset asserted mid-stream, between clock edges
    in_val = 4'b1111; out_rdy = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_val", 128'(out_val), 128'(0));
    check("async_rst_rdy", 128'(in_rdy), 128'(0));
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
    in_val = 4'b1111; out_rdy = 1'b1;
    step();
    check("post_rst_grant", 128'(seen_rdy), 128'(4'b0001));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
